adc_sequencer: RTL

ADC_SEQUENCER -- requirements
Module: adc_sequencer

---
 rtl/adc_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/adc_sequencer.sv
// Multi-channel ADC scan sequencer: timer/software triggered scans over a channel mask,
// one conversion per set bit, with per-conversion timeout and sticky overrun/timeout status.
module adc_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cfg_enable,
    input  logic [NUM_CH-1:0]     cfg_ch_mask,
    input  logic [15:0]           cfg_period,
    input  logic                  sw_trigger,
    input  logic                  status_clr,
    output logic                  adc_start,
    output logic [2:0]            adc_ch_sel,
    input  logic                  adc_done,
    input  logic [DATA_WIDTH-1:0] adc_data,
    output logic                  result_valid,
    output logic [2:0]            result_ch,
    output logic [DATA_WIDTH-1:0] result_data,
    output logic                  scan_done,
    output logic [DATA_WIDTH-1:0] status
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] STORE = 2'd3;

    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [1:0]            state_q, state_d;
    logic [15:0]           timer_q, timer_d;
    logic [NUM_CH-1:0]     mask_q, mask_d;
    logic [2:0]            cur_ch_q, cur_ch_d;
    logic [2:0]            last_ch_q, last_ch_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  overrun_q, overrun_d;
    logic                  timeout_q, timeout_d;
    logic                  scan_done_q, scan_done_d;

    logic       timer_trig;
    logic       trigger;
    logic       advance;
    logic       timeout_set;
    logic [2:0] first_ch;
    logic [2:0] next_ch;
    logic       next_found;

    // Timer reloads from cfg_period whenever it is idle or has just fired.
    always_comb begin
        timer_d    = timer_q;
        timer_trig = 1'b0;
        if (!cfg_enable || (cfg_period == '0)) begin
            timer_d = cfg_period;
        end else if (timer_q == 16'd1) begin
            timer_trig = 1'b1;
            timer_d    = cfg_period;
        end else if (timer_q == '0) begin
            timer_d = cfg_period;
        end else begin
            timer_d = timer_q - 16'd1;
        end
    end

    assign trigger = timer_trig | sw_trigger;

    // Descending scan leaves the lowest qualifying index in each result.
    always_comb begin
        first_ch   = '0;
        next_ch    = '0;
        next_found = 1'b0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (cfg_ch_mask[i]) begin
                first_ch = 3'(i);
            end
            if (mask_q[i] && (3'(i) > cur_ch_q)) begin
                next_ch    = 3'(i);
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        cur_ch_d    = cur_ch_q;
        last_ch_d   = last_ch_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        scan_done_d = 1'b0;
        advance     = 1'b0;
        timeout_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (trigger && (cfg_ch_mask != '0)) begin
                    mask_d   = cfg_ch_mask;
                    cur_ch_d = first_ch;
                    state_d  = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (adc_done) begin
                    data_d    = adc_data;
                    last_ch_d = cur_ch_q;
                    state_d   = STORE;
                end else if (cnt_q == CntLast) begin
                    timeout_set = 1'b1;
                    advance     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            STORE: begin
                advance = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            if (next_found) begin
                cur_ch_d = next_ch;
                state_d  = START;
            end else begin
                scan_done_d = 1'b1;
                state_d     = IDLE;
            end
        end
    end

    // Set events take priority over a same-cycle clear.
    assign overrun_d = (trigger && (state_q != IDLE)) | (overrun_q & ~status_clr);
    assign timeout_d = timeout_set | (timeout_q & ~status_clr);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            mask_q      <= '0;
            cur_ch_q    <= '0;
            last_ch_q   <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            mask_q      <= mask_d;
            cur_ch_q    <= cur_ch_d;
            last_ch_q   <= last_ch_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            scan_done_q <= scan_done_d;
        end
    end

    assign adc_start    = (state_q == START);
    assign adc_ch_sel   = cur_ch_q;
    assign result_valid = (state_q == STORE);
    assign result_ch    = cur_ch_q;
    assign result_data  = data_q;
    assign scan_done    = scan_done_q;

    always_comb begin
        status      = '0;
        status[0]   = (state_q != IDLE);
        status[1]   = overrun_q;
        status[2]   = timeout_q;
        status[6:4] = last_ch_q;
    end

endmodule
